// File: rtl/cavlc_pkg.sv
// Shared types for the CAVLC coeff_token encoder/packer.
// Holds the symbol and codeword structs, the longest codeword length, the
// packer state encoding and two small helpers used by the LUT and the top.
package cavlc_pkg;

    localparam int CT_MAX_LEN = 16;

    typedef struct packed {
        logic [4:0] total_coeff;
        logic [1:0] trailing_ones;
    } ct_sym_t;

    typedef struct packed {
        logic [15:0] code;
        logic [4:0]  len;
    } ct_code_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } ct_state_e;

    // Builds a codeword entry; code is right-aligned in its 16-bit field.
    function automatic ct_code_t ct_code(input logic [4:0] len, input logic [15:0] bits);
        ct_code_t c;
        c.code = bits;
        c.len  = len;
        return c;
    endfunction

    // A symbol is illegal when TrailingOnes exceeds min(TotalCoeff,3) or
    // TotalCoeff exceeds 16.
    function automatic logic ct_is_illegal(input ct_sym_t s);
        logic bad_tc;
        logic bad_t1;
        bad_tc = (s.total_coeff > 5'd16);
        bad_t1 = (s.total_coeff < 5'd3) && ({3'b000, s.trailing_ones} > s.total_coeff);
        return bad_tc | bad_t1;
    endfunction

endpackage

// File: rtl/coeff_token_enc_lut.sv
// coeff_token VLC lookup for the 0<=nC<2 table.
// Purely combinational. Any (TotalCoeff, TrailingOnes) pair that has no
// codeword returns Len=0 and Code=0, so the packer appends nothing for it.
module coeff_token_enc_lut
    import cavlc_pkg::*;
(
    input  logic [4:0]  total_coeff,
    input  logic [1:0]  trailing_ones,
    output logic [15:0] code,
    output logic [4:0]  len
);

    ct_code_t c;

    // Table lookup keyed on {TotalCoeff, TrailingOnes}.
    always_comb begin
        c = ct_code(5'd0, 16'd0);
        case ({total_coeff, trailing_ones})
            {5'd0,  2'd0}: c = ct_code(5'd1,  16'd1);
            {5'd1,  2'd0}: c = ct_code(5'd6,  16'd5);
            {5'd1,  2'd1}: c = ct_code(5'd2,  16'd1);
            {5'd2,  2'd0}: c = ct_code(5'd8,  16'd7);
            {5'd2,  2'd1}: c = ct_code(5'd6,  16'd4);
            {5'd2,  2'd2}: c = ct_code(5'd3,  16'd1);
            {5'd3,  2'd0}: c = ct_code(5'd9,  16'd7);
            {5'd3,  2'd1}: c = ct_code(5'd8,  16'd6);
            {5'd3,  2'd2}: c = ct_code(5'd7,  16'd5);
            {5'd3,  2'd3}: c = ct_code(5'd5,  16'd3);
            {5'd4,  2'd0}: c = ct_code(5'd10, 16'd7);
            {5'd4,  2'd1}: c = ct_code(5'd9,  16'd6);
            {5'd4,  2'd2}: c = ct_code(5'd8,  16'd5);
            {5'd4,  2'd3}: c = ct_code(5'd6,  16'd3);
            {5'd5,  2'd0}: c = ct_code(5'd11, 16'd7);
            {5'd5,  2'd1}: c = ct_code(5'd10, 16'd6);
            {5'd5,  2'd2}: c = ct_code(5'd9,  16'd5);
            {5'd5,  2'd3}: c = ct_code(5'd7,  16'd4);
            {5'd6,  2'd0}: c = ct_code(5'd13, 16'd15);
            {5'd6,  2'd1}: c = ct_code(5'd11, 16'd6);
            {5'd6,  2'd2}: c = ct_code(5'd10, 16'd5);
            {5'd6,  2'd3}: c = ct_code(5'd8,  16'd4);
            {5'd7,  2'd0}: c = ct_code(5'd13, 16'd11);
            {5'd7,  2'd1}: c = ct_code(5'd13, 16'd14);
            {5'd7,  2'd2}: c = ct_code(5'd11, 16'd5);
            {5'd7,  2'd3}: c = ct_code(5'd9,  16'd4);
            {5'd8,  2'd0}: c = ct_code(5'd13, 16'd8);
            {5'd8,  2'd1}: c = ct_code(5'd13, 16'd10);
            {5'd8,  2'd2}: c = ct_code(5'd13, 16'd13);
            {5'd8,  2'd3}: c = ct_code(5'd10, 16'd4);
            {5'd9,  2'd0}: c = ct_code(5'd14, 16'd15);
            {5'd9,  2'd1}: c = ct_code(5'd14, 16'd14);
            {5'd9,  2'd2}: c = ct_code(5'd13, 16'd9);
            {5'd9,  2'd3}: c = ct_code(5'd11, 16'd4);
            {5'd10, 2'd0}: c = ct_code(5'd14, 16'd11);
            {5'd10, 2'd1}: c = ct_code(5'd14, 16'd10);
            {5'd10, 2'd2}: c = ct_code(5'd14, 16'd13);
            {5'd10, 2'd3}: c = ct_code(5'd13, 16'd12);
            {5'd11, 2'd0}: c = ct_code(5'd15, 16'd15);
            {5'd11, 2'd1}: c = ct_code(5'd15, 16'd14);
            {5'd11, 2'd2}: c = ct_code(5'd14, 16'd9);
            {5'd11, 2'd3}: c = ct_code(5'd14, 16'd12);
            {5'd12, 2'd0}: c = ct_code(5'd15, 16'd11);
            {5'd12, 2'd1}: c = ct_code(5'd15, 16'd10);
            {5'd12, 2'd2}: c = ct_code(5'd15, 16'd13);
            {5'd12, 2'd3}: c = ct_code(5'd14, 16'd8);
            {5'd13, 2'd0}: c = ct_code(5'd16, 16'd15);
            {5'd13, 2'd1}: c = ct_code(5'd15, 16'd1);
            {5'd13, 2'd2}: c = ct_code(5'd15, 16'd9);
            {5'd13, 2'd3}: c = ct_code(5'd15, 16'd12);
            {5'd14, 2'd0}: c = ct_code(5'd16, 16'd11);
            {5'd14, 2'd1}: c = ct_code(5'd16, 16'd14);
            {5'd14, 2'd2}: c = ct_code(5'd16, 16'd13);
            {5'd14, 2'd3}: c = ct_code(5'd15, 16'd8);
            {5'd15, 2'd0}: c = ct_code(5'd16, 16'd7);
            {5'd15, 2'd1}: c = ct_code(5'd16, 16'd10);
            {5'd15, 2'd2}: c = ct_code(5'd16, 16'd9);
            {5'd15, 2'd3}: c = ct_code(5'd16, 16'd12);
            {5'd16, 2'd0}: c = ct_code(5'd16, 16'd4);
            {5'd16, 2'd1}: c = ct_code(5'd16, 16'd6);
            {5'd16, 2'd2}: c = ct_code(5'd16, 16'd5);
            {5'd16, 2'd3}: c = ct_code(5'd16, 16'd8);
            default:       c = ct_code(5'd0,  16'd0);
        endcase
    end

    assign code = c.code;
    assign len  = c.len;

endmodule

// File: rtl/coeff_token_packer.sv
// CAVLC coeff_token encoder and MSB-first bit packer (0<=nC<2 table).
// Optional feature macro: CT_ERR_CHECK_EN -- when defined, illegal symbols are
// accepted but not packed and ErrIllegal pulses; otherwise ErrIllegal is 0.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; valid never waits on ready, and a source holds its payload stable
// while valid is high and ready is low. InReady and all outputs are registered.
//
// Accumulator is OUT_W+16 bits, first-coded bit at the MSB. Symbols are only
// accepted while fewer than OUT_W bits are held, and a word is only offered
// while at least OUT_W bits are held, so push and pop never coincide.
module coeff_token_packer
    import cavlc_pkg::*;
#(
    parameter int OUT_W = 32
)
(
    input  logic             Clk,
    input  logic             nReset,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       TotalCoeff,
    input  logic [1:0]       TrailingOnes,
    input  logic             FlushReq,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [OUT_W-1:0] OutWord,
    output logic [5:0]       OutBits,
    output logic             OutLast,
    output logic             FlushDone,
    output logic             ErrIllegal,
    output logic             DbgState
);

    localparam int ACC_W = OUT_W + CT_MAX_LEN;
    localparam int CNT_W = $clog2(OUT_W + CT_MAX_LEN + 1);
    localparam logic [CNT_W-1:0] WORD_CNT = CNT_W'(OUT_W);

    ct_state_e          state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [OUT_W-1:0]   out_word_q, out_word_d;
    logic [5:0]         out_bits_q, out_bits_d;
    logic               out_last_q, out_last_d;
    logic               flush_done_q, flush_done_d;
    logic               err_q, err_d;

    logic [15:0]           lut_code;
    logic [4:0]            lut_len;
    logic [CT_MAX_LEN-1:0] code_left;
    logic [ACC_W-1:0]      push_vec;
    logic                  accept;
    logic                  pop;

    coeff_token_enc_lut u_lut (
        .total_coeff   (TotalCoeff),
        .trailing_ones (TrailingOnes),
        .code          (lut_code),
        .len           (lut_len)
    );

    // Left-justify the codeword, then drop it just below the bits already held.
    always_comb begin
        code_left = lut_code << (5'(CT_MAX_LEN) - lut_len);
        push_vec  = {code_left, {OUT_W{1'b0}}} >> cnt_q;
    end

`ifdef CT_ERR_CHECK_EN
    ct_sym_t sym;
    logic    illegal;

    // Legality of the symbol currently presented.
    always_comb begin
        sym.total_coeff   = TotalCoeff;
        sym.trailing_ones = TrailingOnes;
        illegal           = ct_is_illegal(sym);
    end
`endif

    // Next-state: push/pop on the accumulator, FSM, then registered outputs
    // derived from the next accumulator contents.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        flush_done_d = 1'b0;
        err_d        = 1'b0;
        in_ready_d   = 1'b0;
        out_valid_d  = 1'b0;
        out_word_d   = '0;
        out_bits_d   = '0;
        out_last_d   = 1'b0;

        accept = InValid & in_ready_q;
        pop    = out_valid_q & OutReady;

        if (accept) begin
`ifdef CT_ERR_CHECK_EN
            if (illegal) begin
                err_d = 1'b1;
            end else begin
                acc_d = acc_q | push_vec;
                cnt_d = cnt_q + CNT_W'(lut_len);
            end
`else
            acc_d = acc_q | push_vec;
            cnt_d = cnt_q + CNT_W'(lut_len);
`endif
        end

        if (pop) begin
            if (out_last_q) begin
                acc_d        = '0;
                cnt_d        = '0;
                state_d      = RUN;
                flush_done_d = 1'b1;
            end else begin
                acc_d = acc_q << OUT_W;
                cnt_d = cnt_q - WORD_CNT;
            end
        end

        case (state_q)
            RUN: begin
                if (FlushReq) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // Nothing left to emit: finish the flush straight away.
                if (cnt_q == '0) begin
                    state_d      = RUN;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = RUN;
        endcase

        if (cnt_d >= WORD_CNT) begin
            out_valid_d = 1'b1;
            out_word_d  = acc_d[ACC_W-1 -: OUT_W];
            out_bits_d  = 6'(OUT_W);
        end else if (state_d == FLUSH && cnt_d != '0) begin
            out_valid_d = 1'b1;
            out_word_d  = acc_d[ACC_W-1 -: OUT_W];
            out_bits_d  = 6'(cnt_d);
            out_last_d  = 1'b1;
        end

        if (state_d == RUN) begin
            in_ready_d = (cnt_d < WORD_CNT);
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge Clk) begin
        if (!nReset) begin
            state_q      <= RUN;
            acc_q        <= '0;
            cnt_q        <= '0;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            out_word_q   <= '0;
            out_bits_q   <= '0;
            out_last_q   <= 1'b0;
            flush_done_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            out_word_q   <= out_word_d;
            out_bits_q   <= out_bits_d;
            out_last_q   <= out_last_d;
            flush_done_q <= flush_done_d;
            err_q        <= err_d;
        end
    end

    assign InReady    = in_ready_q;
    assign OutValid   = out_valid_q;
    assign OutWord    = out_word_q;
    assign OutBits    = out_bits_q;
    assign OutLast    = out_last_q;
    assign FlushDone  = flush_done_q;
    assign ErrIllegal = err_q;
    assign DbgState   = (state_q == FLUSH);

endmodule
